// File: rtl/return_addr_stack.sv
// Return-address stack fed by the control unit's push/pop strobes, qualified by the commit pulse.
// Build option RETURN_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module return_addr_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  clear_err,
    output logic [ADDR_WIDTH-1:0] top_addr,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PTR_W = $clog2(DEPTH);
`ifdef RETURN_STACK_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      sp, sp_top;
    logic                  op_push, op_pop, op_tail;
    logic                  eff_push, replace, push_ok, pop_ok;
    logic                  set_ovf, set_unf;
    logic                  mem_we;
    logic [PTR_W-1:0]      mem_wa;

    assign sp_top = sp - PTR_W'(1);
    assign empty  = (count == '0);
    assign full   = (count == CNT_WIDTH'(DEPTH));

    // Tail call on an empty stack degenerates to a plain push.
    assign op_push  = commit & push & ~pop;
    assign op_pop   = commit & pop & ~push;
    assign op_tail  = commit & push & pop;
    assign eff_push = op_push | (op_tail & empty);
    assign replace  = op_tail & ~empty;
    assign push_ok  = eff_push & (~full | WRAP);
    assign pop_ok   = op_pop & ~empty;
    assign set_ovf  = eff_push & full;
    assign set_unf  = op_pop & empty;

    assign mem_we = replace | push_ok;
    assign mem_wa = replace ? sp_top : sp;

    assign top_addr = empty ? '0 : mem[sp_top];

    // Storage is deliberately not reset; the reset gate only blocks a write during reset.
    always_ff @(posedge clk) begin
        if (reset && mem_we)
            mem[mem_wa] <= push_addr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)
                sp <= sp + PTR_W'(1);
            else if (pop_ok)
                sp <= sp_top;
            if (eff_push && !full)
                count <= count + CNT_WIDTH'(1);
            else if (pop_ok)
                count <= count - CNT_WIDTH'(1);
            overflow  <= set_ovf | (overflow & ~clear_err);
            underflow <= set_unf | (underflow & ~clear_err);
        end
    end
endmodule
